// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared constants for the text-mode display path. The write controller and
// the framebuffer read-side address calculation both use this package.
//   COLS, ROWS  : character grid geometry
//   ADDR_W      : text RAM address width (COLS*ROWS must fit)
//   BLANK       : fill character used by clear and backspace
//   CHR_*       : recognised control codes
//   state_t     : write controller FSM states
// -----------------------------------------------------------------------------
package text_pkg;

   localparam int          COLS   = 80;
   localparam int          ROWS   = 30;
   localparam int          ADDR_W = 12;
   localparam logic [7:0]  BLANK  = 8'h20;

   localparam logic [7:0]  CHR_BS = 8'h08;
   localparam logic [7:0]  CHR_LF = 8'h0A;
   localparam logic [7:0]  CHR_FF = 8'h0C;
   localparam logic [7:0]  CHR_CR = 8'h0D;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

endpackage

// File: rtl/text_cursor.sv
// -----------------------------------------------------------------------------
// text_cursor
// Character cursor for the text RAM. Holds the row/column registers and
// presents the linear RAM address of the current cell.
//   clk, reset_n : clock, synchronous active-low reset (cursor -> (0,0))
//   home         : force cursor to (0,0)
//   advance      : step one column, wrapping to the next row and then to row 0
//   newline      : column 0 of the next row (wraps to row 0)
//   cr           : column 0 of the current row
//   back         : step back one column; never leaves the current row
//   col, row     : current position
//   addr         : row*COLS + col
// Priority when several controls are high: home, advance, newline, cr, back.
// -----------------------------------------------------------------------------
module text_cursor
   import text_pkg::*;
#(
   parameter int COLS   = text_pkg::COLS,
   parameter int ROWS   = text_pkg::ROWS,
   parameter int ADDR_W = text_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              home,
   input  logic              advance,
   input  logic              newline,
   input  logic              cr,
   input  logic              back,
   output logic [6:0]        col,
   output logic [4:0]        row,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

   logic [4:0] row_next;

   // Row after a line step; wraps to the top instead of scrolling.
   always_comb begin
      row_next = (row == ROW_LAST) ? '0 : row + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n || home) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row_next;
         end else begin
            col <= col + 7'd1;
         end
      end else if (newline) begin
         col <= '0;
         row <= row_next;
      end else if (cr) begin
         col <= '0;
      end else if (back) begin
         if (col != '0) begin
            col <= col - 7'd1;
         end
      end
   end

   // Widen before multiplying so row*COLS never truncates.
   always_comb begin
      addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   end

endmodule

// File: rtl/text_write_ctrl.sv
// -----------------------------------------------------------------------------
// text_write_ctrl
// Sole writer of the dual-port text RAM used by the VGA character renderer.
// Decodes the SPI byte stream (printable ASCII plus CR/LF/BS/FF), moves the
// cursor and drives the RAM write port. After reset and on form-feed it
// sweeps BLANK over the whole screen, dropping any bytes that arrive meanwhile.
//   clk, reset_n           : clock, synchronous active-low reset
//   byte_valid, byte_data  : one-cycle strobe per received byte
//   wr_en, wr_addr, wr_data: text RAM write port (addr/data hold when idle)
//   busy                   : clear sweep in progress
//   cursor_col, cursor_row : current cursor position
//   drop                   : one-cycle pulse per discarded byte
// All outputs are registered; a byte accepted at edge N acts at edge N+1.
// -----------------------------------------------------------------------------
module text_write_ctrl
   import text_pkg::*;
#(
   parameter int         COLS   = text_pkg::COLS,
   parameter int         ROWS   = text_pkg::ROWS,
   parameter int         ADDR_W = text_pkg::ADDR_W,
   parameter logic [7:0] BLANK  = text_pkg::BLANK
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic [6:0]        cursor_col,
   output logic [4:0]        cursor_row,
   output logic              drop
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

   state_t            state;
   logic [ADDR_W-1:0] sweep_cnt;

   logic              cur_home;
   logic              cur_advance;
   logic              cur_newline;
   logic              cur_cr;
   logic              cur_back;
   logic [ADDR_W-1:0] cur_addr;

   // Cursor control decode. The cursor homes on the last sweep write so it
   // is at (0,0) exactly when the controller returns to IDLE.
   always_comb begin
      cur_home    = (state == ST_CLEAR) && (sweep_cnt == LAST_ADDR);
      cur_advance = 1'b0;
      cur_newline = 1'b0;
      cur_cr      = 1'b0;
      cur_back    = 1'b0;
      if ((state == ST_IDLE) && byte_valid) begin
         if (is_printable(byte_data)) begin
            cur_advance = 1'b1;
         end else begin
            case (byte_data)
               CHR_CR:  cur_cr      = 1'b1;
               CHR_LF:  cur_newline = 1'b1;
               CHR_BS:  cur_back    = (cursor_col != '0);
               default: ;
            endcase
         end
      end
   end

   text_cursor #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_cursor (
      .clk     (clk),
      .reset_n (reset_n),
      .home    (cur_home),
      .advance (cur_advance),
      .newline (cur_newline),
      .cr      (cur_cr),
      .back    (cur_back),
      .col     (cursor_col),
      .row     (cursor_row),
      .addr    (cur_addr)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_CLEAR;
         sweep_cnt <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= BLANK;
         busy      <= 1'b1;
         drop      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         drop  <= 1'b0;
         case (state)
            ST_CLEAR: begin
               wr_en   <= 1'b1;
               wr_addr <= sweep_cnt;
               wr_data <= BLANK;
               drop    <= byte_valid;
               if (sweep_cnt == LAST_ADDR) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  sweep_cnt <= '0;
               end else begin
                  sweep_cnt <= sweep_cnt + ADDR_W'(1);
               end
            end
            ST_IDLE: begin
               if (byte_valid) begin
                  if (is_printable(byte_data)) begin
                     wr_en   <= 1'b1;
                     wr_addr <= cur_addr;
                     wr_data <= byte_data;
                  end else if (byte_data == CHR_BS) begin
                     // Blank the cell the cursor steps back onto; col>0 here,
                     // so cur_addr-1 stays within the current row.
                     if (cursor_col != '0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cur_addr - ADDR_W'(1);
                        wr_data <= BLANK;
                     end
                  end else if (byte_data == CHR_FF) begin
                     state     <= ST_CLEAR;
                     sweep_cnt <= '0;
                     busy      <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_CLEAR;
            end
         endcase
      end
   end

endmodule
